// File: rtl/ad7606_acq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ad7606_acq_ctrl_pkg
// Shared definitions for the AD7606 acquisition engine: FSM state encoding,
// FIFO word field layout, oversampling code limit and small helper functions.
// ---------------------------------------------------------------------------
package ad7606_acq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARST,
    ST_WAIT,
    ST_CONV,
    ST_BUSY,
    ST_RD_LO,
    ST_RD_HI
  } state_t;

  // Word layout: [31] ch0 marker, [30:20] frame sequence, [19:16] channel, [15:0] sample
  localparam int SEQ_W = 11;
  localparam int CHF_W = 4;
  localparam int SMP_W = 16;

  // OS code 3'b111 is not a valid AD7606 ratio; it is clamped to the largest legal one.
  localparam logic [2:0] OS_MAX = 3'd6;

  function automatic logic [2:0] os_clamp(input logic [2:0] code);
    return (code > OS_MAX) ? OS_MAX : code;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] m);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, m[i]};
    return n;
  endfunction

  function automatic logic [31:0] make_word(input logic first, input logic [SEQ_W-1:0] seq,
                                            input logic [CHF_W-1:0] ch, input logic [SMP_W-1:0] smp);
    return {first, seq, ch, smp};
  endfunction

endpackage

// File: rtl/ad7606_acq_ctrl_if.sv
// ---------------------------------------------------------------------------
// ad7606_acq_ctrl_if
// AD7606 pin bundle.
//   master (controller): drives ad_os, ad_cs, ad_rd, ad_reset, ad_convst;
//                        receives ad_data, ad_busy, first_data.
//   slave  (ADC side)  : the mirror image.
// ---------------------------------------------------------------------------
interface ad7606_acq_ctrl_if;
  logic [15:0] ad_data;
  logic        ad_busy;
  logic        first_data;
  logic [2:0]  ad_os;
  logic        ad_cs;
  logic        ad_rd;
  logic        ad_reset;
  logic        ad_convst;

  modport master (
    input  ad_data, ad_busy, first_data,
    output ad_os, ad_cs, ad_rd, ad_reset, ad_convst
  );

  modport slave (
    output ad_data, ad_busy, first_data,
    input  ad_os, ad_cs, ad_rd, ad_reset, ad_convst
  );
endinterface

// File: rtl/ad7606_acq_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// ad7606_acq_ctrl_fifo
// Single-clock FIFO, DW bits x 2**AW words, registered read data.
//   clk, rst      clock, asynchronous active-high reset
//   i_clr         synchronous flush (pointers and level to zero, dout holds)
//   i_push/i_wdata write request (ignored when full)
//   i_pop         read request (ignored when empty); o_dout valid next cycle
//   o_empty/o_full/o_level  status, level counts stored words
// ---------------------------------------------------------------------------
module ad7606_acq_ctrl_fifo #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_dout,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_level
);
  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [DW-1:0] r_dout;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && (r_level != (AW+1)'(DEPTH));
  assign w_pop   = i_pop && (r_level != '0);
  assign o_dout  = r_dout;
  assign o_level = r_level;
  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == (AW+1)'(DEPTH));

  // Storage array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_dout   <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_dout   <= r_mem[r_rd_ptr];
      end
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/ad7606_acq_ctrl.sv
// ---------------------------------------------------------------------------
// ad7606_acq_ctrl
// AD7606 acquisition engine: self-timed conversions, masked channel readout,
// oversampling reconfiguration and an integrated FIFO of tagged 32-bit words.
//   clk, rst        clock, asynchronous active-high reset
//   i_en            run enable (level); a running frame always completes
//   i_os_cfg        oversampling code, applied through an ADC reset cycle
//   i_ch_mask       1 = channel stored, sampled at conversion start
//   i_clr           flush FIFO, clear sticky flags, abort frame
//   ad              AD7606 pin bundle (master side)
//   i_rd_en/o_dout  FIFO pop, data valid the cycle after an accepted pop
//   o_empty/o_full/o_level  FIFO status
//   o_overflow      sticky: frame dropped (no room) or conversion period overrun
//   o_sync_err      sticky: first_data missing on ch0 or busy timeout
// ---------------------------------------------------------------------------
module ad7606_acq_ctrl
  import ad7606_acq_ctrl_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int FIFO_AW     = 9,
  parameter int CONV_PERIOD = 250,
  parameter int T_RST       = 5,
  parameter int T_CONV      = 2,
  parameter int T_RD        = 2,
  parameter int BUSY_TO     = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic [2:0]         i_os_cfg,
  input  logic [NUM_CH-1:0]  i_ch_mask,
  input  logic               i_clr,
  ad7606_acq_ctrl_if.master  ad,
  input  logic               i_rd_en,
  output logic [31:0]        o_dout,
  output logic               o_empty,
  output logic               o_full,
  output logic [FIFO_AW:0]   o_level,
  output logic               o_overflow,
  output logic               o_sync_err
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int PER_W = $clog2(CONV_PERIOD + 1);
  localparam int TMR_W = 16;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t              r_state;
  logic [TMR_W-1:0]    r_tmr;
  logic [PER_W-1:0]    r_per;
  logic [NUM_CH-1:0]   r_mask;
  logic [CH_W-1:0]     r_ch;
  logic [SEQ_W-1:0]    r_seq;
  logic [SMP_W-1:0]    r_sample;
  logic                r_busy_seen;
  logic                r_push;
  logic [31:0]         r_wdata;
  logic                r_overflow;
  logic                r_sync_err;
  logic                r_cs;
  logic                r_rd;
  logic                r_convst;
  logic                r_reset;
  logic [2:0]          r_os;

  logic [7:0]          w_mask8;
  logic [FIFO_AW:0]    w_level;
  logic [FIFO_AW:0]    w_free;
  logic                w_room;
  logic                w_per_tick;
  logic [2:0]          w_os_tgt;

  for (genvar gi = 0; gi < 8; gi++) begin : g_mask
    if (gi < NUM_CH) begin : g_used
      assign w_mask8[gi] = i_ch_mask[gi];
    end else begin : g_pad
      assign w_mask8[gi] = 1'b0;
    end
  end

  // Space for the whole frame is reserved before converting, so pushes never meet full.
  assign w_free     = (FIFO_AW+1)'(DEPTH) - w_level;
  assign w_room     = 32'(w_free) >= 32'(popcount8(w_mask8));
  assign w_per_tick = (r_per == PER_W'(CONV_PERIOD - 1));
  assign w_os_tgt   = os_clamp(i_os_cfg);

  assign ad.ad_cs     = r_cs;
  assign ad.ad_rd     = r_rd;
  assign ad.ad_convst = r_convst;
  assign ad.ad_reset  = r_reset;
  assign ad.ad_os     = r_os;
  assign o_level      = w_level;
  assign o_overflow   = r_overflow;
  assign o_sync_err   = r_sync_err;

  // ad_busy is taken directly; it is expected to be retimed in the pad ring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tmr       <= '0;
      r_per       <= '0;
      r_mask      <= '0;
      r_ch        <= '0;
      r_seq       <= '0;
      r_sample    <= '0;
      r_busy_seen <= 1'b0;
      r_push      <= 1'b0;
      r_wdata     <= '0;
      r_overflow  <= 1'b0;
      r_sync_err  <= 1'b0;
      r_cs        <= 1'b1;
      r_rd        <= 1'b1;
      r_convst    <= 1'b1;
      r_reset     <= 1'b1;
      r_os        <= '0;
    end else begin
      r_push <= 1'b0;
      // Period counter free-runs and wraps; CONV is only entered on a wrap,
      // so each conversion start restarts the period.
      r_per  <= w_per_tick ? '0 : r_per + 1'b1;
      if (i_clr) begin
        r_state    <= ST_WAIT;
        r_tmr      <= '0;
        r_cs       <= 1'b1;
        r_rd       <= 1'b1;
        r_convst   <= 1'b1;
        r_reset    <= 1'b0;
        r_overflow <= 1'b0;
        r_sync_err <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_per <= '0;
            if (i_en) begin
              r_state <= ST_ARST;
              r_reset <= 1'b1;
              r_tmr   <= '0;
            end
          end
          ST_ARST: begin
            if (r_tmr == TMR_W'(T_RST - 1)) begin
              r_reset <= 1'b0;
              r_os    <= w_os_tgt;
              r_state <= ST_WAIT;
            end else begin
              r_tmr <= r_tmr + 1'b1;
            end
          end
          ST_WAIT: begin
            if (!i_en) begin
              r_state <= ST_IDLE;
            end else if (w_os_tgt != r_os) begin
              r_state <= ST_ARST;
              r_reset <= 1'b1;
              r_tmr   <= '0;
            end else if (w_per_tick) begin
              if (w_room) begin
                r_state  <= ST_CONV;
                r_convst <= 1'b0;
                r_tmr    <= '0;
                r_mask   <= i_ch_mask;
              end else begin
                r_overflow <= 1'b1;
              end
            end
          end
          ST_CONV: begin
            if (r_tmr == TMR_W'(T_CONV - 1)) begin
              r_convst    <= 1'b1;
              r_state     <= ST_BUSY;
              r_tmr       <= '0;
              r_busy_seen <= 1'b0;
            end else begin
              r_tmr <= r_tmr + 1'b1;
            end
          end
          ST_BUSY: begin
            if (w_per_tick) r_overflow <= 1'b1;
            if (r_busy_seen && !ad.ad_busy) begin
              r_state <= ST_RD_LO;
              r_cs    <= 1'b0;
              r_rd    <= 1'b0;
              r_ch    <= '0;
              r_tmr   <= '0;
            end else if (r_tmr == TMR_W'(BUSY_TO - 1)) begin
              r_sync_err <= 1'b1;
              r_state    <= ST_ARST;
              r_reset    <= 1'b1;
              r_tmr      <= '0;
            end else begin
              r_tmr <= r_tmr + 1'b1;
              if (ad.ad_busy) r_busy_seen <= 1'b1;
            end
          end
          ST_RD_LO: begin
            if (w_per_tick) r_overflow <= 1'b1;
            if (r_tmr == TMR_W'(T_RD - 1)) begin
              r_tmr    <= '0;
              r_sample <= ad.ad_data;
              r_rd     <= 1'b1;
              // A ch0 sync failure aborts before anything of this frame is stored.
              if (r_ch == '0 && !ad.first_data) begin
                r_sync_err <= 1'b1;
                r_cs       <= 1'b1;
                r_reset    <= 1'b1;
                r_state    <= ST_ARST;
              end else begin
                r_state <= ST_RD_HI;
              end
            end else begin
              r_tmr <= r_tmr + 1'b1;
            end
          end
          ST_RD_HI: begin
            if (w_per_tick) r_overflow <= 1'b1;
            if (r_tmr == TMR_W'(T_RD - 1)) begin
              r_tmr   <= '0;
              r_push  <= r_mask[r_ch];
              r_wdata <= make_word(r_ch == '0, r_seq, CHF_W'(r_ch), r_sample);
              if (r_ch == CH_W'(NUM_CH - 1)) begin
                r_cs    <= 1'b1;
                r_seq   <= r_seq + 1'b1;
                r_state <= ST_WAIT;
              end else begin
                r_ch    <= r_ch + 1'b1;
                r_rd    <= 1'b0;
                r_state <= ST_RD_LO;
              end
            end else begin
              r_tmr <= r_tmr + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  ad7606_acq_ctrl_fifo #(
    .AW (FIFO_AW),
    .DW (32)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (i_clr),
    .i_push  (r_push),
    .i_wdata (r_wdata),
    .i_pop   (i_rd_en),
    .o_dout  (o_dout),
    .o_empty (o_empty),
    .o_full  (o_full),
    .o_level (w_level)
  );
endmodule

// File: tb/tb_ad7606_acq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ad7606_acq_ctrl
// Directed bench for ad7606_acq_ctrl with a behavioural AD7606 model.
// Small FIFO and short period keep the 2048-frame sequence wrap affordable.
// ---------------------------------------------------------------------------
module tb_ad7606_acq_ctrl;
  localparam int NUM_CH   = 8;
  localparam int FIFO_AW  = 4;
  localparam int DEPTH    = 16;
  localparam int PERIOD   = 28;
  localparam int T_RST    = 5;
  localparam int BUSY_TO  = 40;
  localparam int BUSY_CYC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  os_cfg = 3'd0;
  logic [7:0]  ch_mask = 8'hFF;
  logic        clr = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] dout;
  logic        empty, full, overflow, sync_err;
  logic [FIFO_AW:0] level;

  int n_pass = 0;
  int n_total = 0;

  ad7606_acq_ctrl_if ifc ();

  ad7606_acq_ctrl #(
    .NUM_CH(NUM_CH), .FIFO_AW(FIFO_AW), .CONV_PERIOD(PERIOD), .T_RST(T_RST),
    .T_CONV(2), .T_RD(1), .BUSY_TO(BUSY_TO)
  ) dut (
    .clk(clk), .rst(rst), .i_en(en), .i_os_cfg(os_cfg), .i_ch_mask(ch_mask), .i_clr(clr),
    .ad(ifc), .i_rd_en(rd_en), .o_dout(dout), .o_empty(empty), .o_full(full),
    .o_level(level), .o_overflow(overflow), .o_sync_err(sync_err)
  );

  always #10 clk = ~clk;

  // ---------------- ADC model ----------------
  logic cv_q = 1'b1;
  logic rd_q = 1'b1;
  int   busy_left = 0;
  int   m_ch = 0;
  logic hold_busy = 1'b0;
  logic fd_kill = 1'b0;

  function automatic logic [15:0] smp(input int c);
    return 16'hA000 + 16'(c * 257);
  endfunction

  always @(posedge clk) begin
    cv_q <= ifc.ad_convst;
    rd_q <= ifc.ad_rd;
    if (ifc.ad_convst && !cv_q) begin
      busy_left <= BUSY_CYC;
      m_ch      <= 0;
    end else begin
      if (busy_left > 0 && !hold_busy) busy_left <= busy_left - 1;
      if (ifc.ad_rd && !rd_q) m_ch <= m_ch + 1;
    end
  end

  assign ifc.ad_busy    = (busy_left > 0);
  assign ifc.ad_data    = (!ifc.ad_cs && !ifc.ad_rd) ? smp(m_ch) : 16'h0000;
  assign ifc.first_data = (m_ch == 0) && !fd_kill;

  // ---------------- utilities ----------------
  // sel: 0 level>=arg, 1 cs low, 2 rd low, 3 sync_err, 4 overflow, 5 ad_reset low
  task automatic wait_until(input int sel, input int arg, input int budget, input string name);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      case (sel)
        0: hit = (int'(level) >= arg);
        1: hit = (ifc.ad_cs == 1'b0);
        2: hit = (ifc.ad_rd == 1'b0);
        3: hit = (sync_err == 1'b1);
        4: hit = (overflow == 1'b1);
        5: hit = (ifc.ad_reset == 1'b0);
        default: hit = 1'b1;
      endcase
      if (!hit) @(negedge clk);
    end
    n_total++;
    if (!hit) $display("FAIL %s: event not seen, required within %0d cycles", name, budget);
    else n_pass++;
  endtask

  task automatic pop(output logic [31:0] w);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    w = dout;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset(input string tag);
    n_total++;
    if ({ifc.ad_cs, ifc.ad_rd, ifc.ad_convst, ifc.ad_reset} !== 4'b1111)
      $display("FAIL %s_pins: got %b want 1111", tag, {ifc.ad_cs, ifc.ad_rd, ifc.ad_convst, ifc.ad_reset});
    else n_pass++;
    n_total++;
    if (ifc.ad_os !== 3'd0) $display("FAIL %s_os: got %0d want 0", tag, ifc.ad_os); else n_pass++;
    n_total++;
    if (dout !== 32'h0) $display("FAIL %s_dout: got %h want 0", tag, dout); else n_pass++;
    n_total++;
    if ({empty, full} !== 2'b10) $display("FAIL %s_status: got %b want 10", tag, {empty, full}); else n_pass++;
    n_total++;
    if (level !== '0) $display("FAIL %s_level: got %0d want 0", tag, level); else n_pass++;
    n_total++;
    if ({overflow, sync_err} !== 2'b00) $display("FAIL %s_flags: got %b want 00", tag, {overflow, sync_err});
    else n_pass++;
    $display("reset check (%s) done", tag);
  endtask

  task automatic test_full_frame();
    logic [31:0] w, exp;
    en = 1'b1;
    ch_mask = 8'hFF;
    for (int f = 0; f < 2; f++) begin
      wait_until(0, 8, 200, "frame_ready");
      for (int c = 0; c < 8; c++) begin
        pop(w);
        exp = {(c == 0), 11'(f), 4'(c), smp(c)};
        n_total++;
        if (w !== exp) $display("FAIL frame%0d_ch%0d: got %h want %h", f, c, w, exp);
        else n_pass++;
        $display("pop frame %0d ch %0d word %h", f, c, w);
      end
    end
  endtask

  task automatic test_mask_overflow();
    logic [31:0] w0, w1, w2;
    ch_mask = 8'h05;
    pulse_clr();
    wait_until(4, 0, 700, "mask_overflow");
    n_total++;
    if (level !== 5'(DEPTH)) $display("FAIL mask_level: got %0d want %0d", level, DEPTH); else n_pass++;
    n_total++;
    if ({full, empty, sync_err} !== 3'b100) $display("FAIL mask_status: got %b want 100", {full, empty, sync_err});
    else n_pass++;
    pop(w0);
    pop(w1);
    pop(w2);
    n_total++;
    if ({w0[31], w0[19:0]} !== {1'b1, 4'd0, smp(0)}) $display("FAIL mask_w0: got %h want ch0 A000", w0);
    else n_pass++;
    n_total++;
    if ({w1[31], w1[30:20], w1[19:0]} !== {1'b0, w0[30:20], 4'd2, smp(2)})
      $display("FAIL mask_w1: got %h want ch2 A202 same seq as %h", w1, w0);
    else n_pass++;
    n_total++;
    if ({w2[31], w2[30:20], w2[19:16]} !== {1'b1, w0[30:20] + 11'd1, 4'd0})
      $display("FAIL mask_w2: got %h want ch0 next seq after %h", w2, w0);
    else n_pass++;
    $display("mask test words %h %h %h", w0, w1, w2);
  endtask

  task automatic test_clr();
    ch_mask = 8'h01;
    wait_until(1, 0, 100, "clr_cs_low");
    pulse_clr();
    n_total++;
    if ({level, empty} !== {5'd0, 1'b1}) $display("FAIL clr_level: got %0d/%b want 0/1", level, empty);
    else n_pass++;
    n_total++;
    if ({overflow, sync_err, ifc.ad_cs} !== 3'b001)
      $display("FAIL clr_flags: got %b want 001", {overflow, sync_err, ifc.ad_cs});
    else n_pass++;
    $display("clr mid-frame done level %0d", level);
  endtask

  task automatic test_busy_timeout();
    int n;
    logic [31:0] w;
    hold_busy = 1'b1;
    wait_until(3, 0, 200, "busy_timeout");
    hold_busy = 1'b0;
    n = 0;
    while (ifc.ad_reset && n < 50) begin
      n++;
      @(negedge clk);
    end
    n_total++;
    if (n != T_RST) $display("FAIL busy_reset_len: got %0d want %0d", n, T_RST); else n_pass++;
    n_total++;
    if ({overflow, level} !== {1'b1, 5'd0}) $display("FAIL busy_ovf_level: got %b/%0d want 1/0", overflow, level);
    else n_pass++;
    wait_until(0, 1, 200, "busy_resume");
    pop(w);
    n_total++;
    if ({w[31], w[19:0], sync_err} !== {1'b1, 4'd0, smp(0), 1'b1})
      $display("FAIL busy_resume_word: got %h err %b want ch0 A000 err 1", w, sync_err);
    else n_pass++;
    $display("busy timeout recovered, reset %0d cycles, word %h", n, w);
  endtask

  task automatic test_first_data();
    logic [31:0] w;
    ch_mask = 8'hFF;
    fd_kill = 1'b1;
    pulse_clr();
    wait_until(3, 0, 200, "fd_sync_err");
    fd_kill = 1'b0;
    n_total++;
    if ({level, ifc.ad_reset, ifc.ad_cs} !== {5'd0, 1'b1, 1'b1})
      $display("FAIL fd_abort: got lvl %0d rst %b cs %b want 0 1 1", level, ifc.ad_reset, ifc.ad_cs);
    else n_pass++;
    repeat (10) @(negedge clk);
    n_total++;
    if (level !== 5'd0) $display("FAIL fd_no_partial: got %0d want 0", level); else n_pass++;
    wait_until(0, 8, 200, "fd_resume");
    pop(w);
    n_total++;
    if ({w[31], w[19:0]} !== {1'b1, 4'd0, smp(0)}) $display("FAIL fd_resume_word: got %h want ch0 A000", w);
    else n_pass++;
    $display("first_data error recovered, word %h", w);
  endtask

  task automatic test_os();
    int ev;
    ch_mask = 8'h01;
    pulse_clr();
    n_total++;
    if (ifc.ad_os !== 3'd0) $display("FAIL os_before: got %0d want 0", ifc.ad_os); else n_pass++;
    wait_until(1, 0, 100, "os_cs_low");
    os_cfg = 3'd3;
    ev = 0;
    for (int n = 0; n < 100 && ev == 0; n++) begin
      @(negedge clk);
      if (ifc.ad_reset) ev = 1;
      else if (!ifc.ad_convst) ev = 2;
    end
    n_total++;
    if (ev != 1) $display("FAIL os_arst_first: got event %0d want 1 (reset before convst)", ev); else n_pass++;
    wait_until(5, 0, 20, "os_arst_end");
    n_total++;
    if (ifc.ad_os !== 3'd3) $display("FAIL os_after: got %0d want 3", ifc.ad_os); else n_pass++;
    $display("os change applied, ad_os %0d", ifc.ad_os);
  endtask

  task automatic test_rst_mid();
    logic [31:0] w;
    ch_mask = 8'hFF;
    wait_until(0, 2, 300, "rst_words");
    pop(w);
    wait_until(2, 0, 100, "rst_rd_low");
    rst = 1'b1;
    #1;
    test_reset("rst_mid");
    os_cfg = 3'd0;
    ch_mask = 8'h01;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_seq_wrap();
    logic [31:0] w, exp;
    int fails;
    fails = 0;
    for (int i = 0; i <= 2048; i++) begin
      wait_until(0, 1, 100, "wrap_frame");
      if (level == '0) break;
      pop(w);
      exp = {1'b1, 11'(i), 4'd0, smp(0)};
      n_total++;
      if (w !== exp) begin
        fails++;
        $display("FAIL seq_%0d: got %h want %h", i, w, exp);
      end else n_pass++;
      if (i >= 2046) $display("wrap pop %0d word %h", i, w);
    end
    $display("sequence wrap test done, %0d word errors", fails);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset("por");
    rst = 1'b0;
    @(negedge clk);
    test_full_frame();
    test_mask_overflow();
    test_clr();
    test_busy_timeout();
    test_first_data();
    test_os();
    test_rst_mid();
    test_seq_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
